// File: rtl/pa_dtu_pcfifo_sched_pkg.sv
// Shared constants and encodings for the DTU PC-FIFO read scheduler.
`ifndef TDT_PCFIFO_DEPTH
`define TDT_PCFIFO_DEPTH 8
`endif
`ifndef TDT_PA_WIDTH
`define TDT_PA_WIDTH 32
`endif

package pa_dtu_pcfifo_sched_pkg;

    localparam int DEPTH     = `TDT_PCFIFO_DEPTH;
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int PA_WIDTH  = `TDT_PA_WIDTH;

    // Scheduler state: RUN lets the FIFO record, STOP and HALT freeze writes.
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_STOP = 2'b01,
        ST_HALT = 2'b10
    } sched_state_e;

    // Which requester owned the last read-port grant.
    typedef enum logic {
        RR_DM  = 1'b0,
        RR_TRC = 1'b1
    } rr_last_e;

endpackage

// File: rtl/pa_dtu_pcfifo_sched_if.sv
// Debug-read, trace-drain and FIFO read-port signals of the scheduler.
//
// Handshakes, all zero latency and combinational in the request cycle:
//   dm : dm_rd_req is a level; dm_rd_ack answers it in the same cycle, with
//        dm_rd_empty qualifying that no entry existed. A request still high
//        the cycle after an ack is a new read.
//   trc: trc_vld/trc_rdy valid-ready; a transfer happens on trc_vld && trc_rdy.
//   fifo: pcfifo_ren advances the FIFO read pointer on the next edge;
//        pcfifo_rd_data is the entry at the current read pointer.
interface pa_dtu_pcfifo_sched_if #(
    parameter int PA_WIDTH = pa_dtu_pcfifo_sched_pkg::PA_WIDTH
);
    logic                dm_rd_req;
    logic                dm_rd_ack;
    logic                dm_rd_empty;
    logic [PA_WIDTH-1:0] dm_rd_data;
    logic                trc_vld;
    logic                trc_rdy;
    logic [PA_WIDTH-1:0] trc_data;
    logic [PA_WIDTH-1:0] pcfifo_rd_data;
    logic                pcfifo_ren;
    logic                pcfifo_wen_blk;

    modport master (
        input  dm_rd_req, trc_rdy, pcfifo_rd_data,
        output dm_rd_ack, dm_rd_empty, dm_rd_data,
        output trc_vld, trc_data, pcfifo_ren, pcfifo_wen_blk
    );

    modport slave (
        output dm_rd_req, trc_rdy, pcfifo_rd_data,
        input  dm_rd_ack, dm_rd_empty, dm_rd_data,
        input  trc_vld, trc_data, pcfifo_ren, pcfifo_wen_blk
    );
endinterface

// File: rtl/pa_dtu_pcfifo_rr_arb.sv
// Two-requester round-robin arbiter (debug module vs trace drain) with a
// registered last-grant; the trace side is marked last out of reset so the
// debug module wins the first tie.
module pa_dtu_pcfifo_rr_arb
    import pa_dtu_pcfifo_sched_pkg::*;
(
    input  logic pcfifo_clk,
    input  logic cpurst_b,
    input  logic req_dm,
    input  logic req_trc,
    output logic gnt_dm,
    output logic gnt_trc
);

    rr_last_e rr_last_q;

    // Grant the requester that did not win last time when both ask.
    always_comb begin
        gnt_dm  = req_dm && (!req_trc || (rr_last_q == RR_TRC));
        gnt_trc = req_trc && !gnt_dm;
    end

    // Remember the most recent winner.
    always_ff @(posedge pcfifo_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rr_last_q <= RR_TRC;
        end else if (gnt_dm) begin
            rr_last_q <= RR_DM;
        end else if (gnt_trc) begin
            rr_last_q <= RR_TRC;
        end
    end

endmodule

// File: rtl/pa_dtu_pcfifo_sched.sv
// PC trace FIFO read scheduler and write-freeze controller. Tracks readable
// entries (the FIFO has no flags), shares the FIFO read port between debug
// reads and the trace drain, and freezes writes on halt or stop-on-full.
module pa_dtu_pcfifo_sched #(
    parameter int DEPTH     = pa_dtu_pcfifo_sched_pkg::DEPTH,
    parameter int PTR_WIDTH = pa_dtu_pcfifo_sched_pkg::PTR_WIDTH,
    parameter int PA_WIDTH  = pa_dtu_pcfifo_sched_pkg::PA_WIDTH
) (
    input  logic                 pcfifo_clk,
    input  logic                 cpurst_b,
    input  logic                 retire_wen_evt,
    input  logic                 rtu_dtu_halt_ack,
    input  logic                 dm_resume,
    input  logic                 cfg_stop_on_full,
    input  logic                 cfg_clr,
    pa_dtu_pcfifo_sched_if.master sif,
    output logic [PTR_WIDTH:0]   sched_cnt,
    output logic                 sched_ovf,
    output logic                 sched_clk_req,
    output logic [1:0]           sched_state
);
    import pa_dtu_pcfifo_sched_pkg::*;

    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] HALF_C  = (PTR_WIDTH+1)'(DEPTH / 2);

    sched_state_e        state_q, state_d;
    logic [PTR_WIDTH:0]  cnt_q, cnt_d;
    logic [PTR_WIDTH:0]  fill_q, fill_d;
    logic                ovf_q, ovf_d;
    logic                cnt_nz, in_halt, wr, rd;
    logic                req_dm, req_trc, gnt_dm, gnt_trc;
    logic [PA_WIDTH-1:0] rd_word;

    assign cnt_nz  = (cnt_q != '0);
    assign in_halt = (state_q == ST_HALT);
    assign rd_word = sif.pcfifo_rd_data;
    // The trace side only competes when it can actually take an entry.
    assign req_dm  = sif.dm_rd_req;
    assign req_trc = sif.trc_rdy && cnt_nz && !in_halt;
    assign wr      = retire_wen_evt && !sif.pcfifo_wen_blk;
    assign rd      = sif.pcfifo_ren;

    pa_dtu_pcfifo_rr_arb u_rr_arb (
        .pcfifo_clk (pcfifo_clk),
        .cpurst_b   (cpurst_b),
        .req_dm     (req_dm),
        .req_trc    (req_trc),
        .gnt_dm     (gnt_dm),
        .gnt_trc    (gnt_trc)
    );

    // State, counters and overflow flag.
    always_ff @(posedge pcfifo_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
        end
    end

    // Counter updates: halt loads the write history, resume drops the stale
    // read position, clear beats ordinary read/write bookkeeping.
    always_comb begin
        cnt_d  = cnt_q;
        fill_d = fill_q;
        ovf_d  = ovf_q;
        if (cfg_clr) begin
            fill_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (wr && (fill_q != DEPTH_C)) fill_d = fill_q + 1'b1;
            if (wr && !rd && (cnt_q == DEPTH_C)) ovf_d = 1'b1;
        end
        if (rtu_dtu_halt_ack) begin
            cnt_d = fill_q;
        end else if (dm_resume && in_halt) begin
            cnt_d = '0;
        end else if (cfg_clr) begin
            cnt_d = '0;
        end else if (wr && !rd) begin
            cnt_d = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + 1'b1;
        end else if (rd && !wr) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Next state with halt > resume > clear > fill-level priority.
    always_comb begin
        state_d = state_q;
        if (rtu_dtu_halt_ack) begin
            state_d = ST_HALT;
        end else if (in_halt && dm_resume) begin
            state_d = ST_RUN;
        end else if (cfg_clr) begin
            state_d = in_halt ? ST_HALT : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (cfg_stop_on_full && (cnt_d == DEPTH_C)) state_d = ST_STOP;
                ST_STOP: if (cnt_d < HALF_C) state_d = ST_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // Handshake outputs; an empty debug read is acked without moving the FIFO.
    always_comb begin
        sif.pcfifo_wen_blk = (state_q != ST_RUN);
        sif.trc_vld        = cnt_nz && !in_halt && !gnt_dm;
        sif.trc_data       = rd_word;
        sif.dm_rd_ack      = gnt_dm;
        sif.dm_rd_empty    = gnt_dm && !cnt_nz;
        sif.dm_rd_data     = (gnt_dm && cnt_nz) ? rd_word : '0;
        sif.pcfifo_ren     = (gnt_dm && cnt_nz) || gnt_trc;
    end

    assign sched_cnt     = cnt_q;
    assign sched_ovf     = ovf_q;
    assign sched_state   = state_q;
    // Any event that must reach the registers keeps the clock gate open.
    assign sched_clk_req = retire_wen_evt || sif.dm_rd_req || sif.trc_vld ||
                           rtu_dtu_halt_ack || dm_resume || cfg_clr;

endmodule

// File: tb/tb_pa_dtu_pcfifo_sched.sv
// Directed vector bench for the PC-FIFO read scheduler.
module tb_pa_dtu_pcfifo_sched;
    import pa_dtu_pcfifo_sched_pkg::*;

    localparam int W = 77;
    localparam logic [1:0] SR = 2'd0;
    localparam logic [1:0] SS = 2'd1;
    localparam logic [1:0] SH = 2'd2;

    typedef struct {
        logic        rst;
        logic        wen, halt, res, sof, clr, dmq, rdy;
        logic [31:0] rdd;
        logic        ack, emp;
        logic [31:0] dmd;
        logic        tv, ren, blk;
        logic [3:0]  cnt;
        logic [1:0]  st;
        logic        ovf;
    } vec_t;

    logic       pcfifo_clk;
    logic       cpurst_b;
    logic       retire_wen_evt, rtu_dtu_halt_ack, dm_resume, cfg_stop_on_full, cfg_clr;
    logic [3:0] sched_cnt;
    logic       sched_ovf, sched_clk_req;
    logic [1:0] sched_state;

    pa_dtu_pcfifo_sched_if #(.PA_WIDTH(32)) sif ();

    pa_dtu_pcfifo_sched dut (
        .pcfifo_clk       (pcfifo_clk),
        .cpurst_b         (cpurst_b),
        .retire_wen_evt   (retire_wen_evt),
        .rtu_dtu_halt_ack (rtu_dtu_halt_ack),
        .dm_resume        (dm_resume),
        .cfg_stop_on_full (cfg_stop_on_full),
        .cfg_clr          (cfg_clr),
        .sif              (sif),
        .sched_cnt        (sched_cnt),
        .sched_ovf        (sched_ovf),
        .sched_clk_req    (sched_clk_req),
        .sched_state      (sched_state)
    );

    // clock
    initial begin
        pcfifo_clk = 1'b0;
        forever #5 pcfifo_clk = ~pcfifo_clk;
    end

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    vec_t         vq[$];

    function automatic vec_t mk(input logic rst, input logic wen, input logic halt,
                                input logic res, input logic sof, input logic clr,
                                input logic dmq, input logic rdy, input logic [31:0] rdd,
                                input logic ack, input logic emp, input logic [31:0] dmd,
                                input logic tv, input logic ren, input logic blk,
                                input logic [3:0] cnt, input logic [1:0] st, input logic ovf);
        vec_t v;
        v.rst = rst; v.wen = wen; v.halt = halt; v.res = res; v.sof = sof;
        v.clr = clr; v.dmq = dmq; v.rdy = rdy; v.rdd = rdd;
        v.ack = ack; v.emp = emp; v.dmd = dmd; v.tv = tv; v.ren = ren;
        v.blk = blk; v.cnt = cnt; v.st = st; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [W-1:0] obs();
        return {sif.dm_rd_ack, sif.dm_rd_empty, sif.dm_rd_data, sif.trc_vld, sif.trc_data,
                sif.pcfifo_ren, sif.pcfifo_wen_blk, sched_cnt, sched_state, sched_ovf,
                sched_clk_req};
    endfunction

    function automatic logic [W-1:0] exp_of(input vec_t v);
        logic clk_req;
        clk_req = v.wen | v.dmq | v.tv | v.halt | v.res | v.clr;
        return {v.ack, v.emp, v.dmd, v.tv, v.rdd, v.ren, v.blk, v.cnt, v.st, v.ovf, clk_req};
    endfunction

    // driver tasks
    task automatic idle_inputs();
        retire_wen_evt   = 1'b0;
        rtu_dtu_halt_ack = 1'b0;
        dm_resume        = 1'b0;
        cfg_stop_on_full = 1'b0;
        cfg_clr          = 1'b0;
        sif.dm_rd_req    = 1'b0;
        sif.trc_rdy      = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        retire_wen_evt     = v.wen;
        rtu_dtu_halt_ack   = v.halt;
        dm_resume          = v.res;
        cfg_stop_on_full   = v.sof;
        cfg_clr            = v.clr;
        sif.dm_rd_req      = v.dmq;
        sif.trc_rdy        = v.rdy;
        sif.pcfifo_rd_data = v.rdd;
    endtask

    // scoreboard
    task automatic check(input string name);
        logic [W-1:0] e;
        logic [W-1:0] a;
        a = obs();
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no expected entry, got %h", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %h want %h", name, a, e);
            end
        end
    endtask

    initial begin
        logic [W-1:0] e;

        // reset
        cpurst_b = 1'b0;
        idle_inputs();
        sif.pcfifo_rd_data = 32'h0;
        #1;
        exp_q.push_back('0);
        check("reset_vals");
        @(negedge pcfifo_clk);
        cpurst_b = 1'b1;

        // three writes, one simultaneous write+read, then drain
        vq.push_back(mk(1, 1,0,0,0,0,0,0, 32'h11,  0,0,0, 0,0,0, 4'd0, SR, 0));
        vq.push_back(mk(0, 1,0,0,0,0,0,0, 32'h12,  0,0,0, 1,0,0, 4'd1, SR, 0));
        vq.push_back(mk(0, 1,0,0,0,0,0,0, 32'h13,  0,0,0, 1,0,0, 4'd2, SR, 0));
        vq.push_back(mk(0, 1,0,0,0,0,0,1, 32'h14,  0,0,0, 1,1,0, 4'd3, SR, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,1, 32'h101, 0,0,0, 1,1,0, 4'd3, SR, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,1, 32'h102, 0,0,0, 1,1,0, 4'd2, SR, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,1, 32'h103, 0,0,0, 1,1,0, 4'd1, SR, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,1, 32'h104, 0,0,0, 0,0,0, 4'd0, SR, 0));

        // overflow: ten writes without stop-on-full, then clear
        for (int k = 0; k < 10; k++)
            vq.push_back(mk(k == 0, 1,0,0,0,0,0,0, 32'h200 + k, 0,0,0, k != 0,0,0,
                            4'((k > 8) ? 8 : k), SR, k == 9));
        vq.push_back(mk(0, 0,0,0,0,1,0,0, 32'h2A0, 0,0,0, 1,0,0, 4'd8, SR, 1));
        vq.push_back(mk(0, 0,0,0,0,0,0,0, 32'h2A1, 0,0,0, 0,0,0, 4'd0, SR, 0));

        // stop-on-full: freeze at 8, blocked writes, drain to 3 returns to RUN
        for (int k = 0; k < 8; k++)
            vq.push_back(mk(k == 0, 1,0,0,1,0,0,0, 32'h300 + k, 0,0,0, k != 0,0,0, 4'(k), SR, 0));
        for (int j = 0; j < 2; j++)
            vq.push_back(mk(0, 1,0,0,1,0,0,0, 32'h310 + j, 0,0,0, 1,0,1, 4'd8, SS, 0));
        for (int j = 0; j < 5; j++)
            vq.push_back(mk(0, 0,0,0,1,0,0,1, 32'h320 + j, 0,0,0, 1,1,1, 4'(8 - j), SS, 0));
        vq.push_back(mk(0, 0,0,0,1,0,0,0, 32'h330, 0,0,0, 1,0,0, 4'd3, SR, 0));

        // halt: five writes, debugger reads five entries plus one empty read
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(k == 0, 1,0,0,0,0,0,0, 32'h400 + k, 0,0,0, k != 0,0,0, 4'(k), SR, 0));
        vq.push_back(mk(0, 0,1,0,0,0,0,0, 32'h410, 0,0,0, 1,0,0, 4'd5, SR, 0));
        for (int j = 0; j < 5; j++)
            vq.push_back(mk(0, 0,0,0,0,0,1,1, 32'h420 + j, 1,0,32'h420 + j, 0,1,1, 4'(5 - j), SH, 0));
        vq.push_back(mk(0, 0,0,0,0,0,1,0, 32'h425, 1,1,0, 0,0,1, 4'd0, SH, 0));
        vq.push_back(mk(0, 0,0,1,0,0,0,0, 32'h430, 0,0,0, 0,0,1, 4'd0, SH, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,0, 32'h431, 0,0,0, 0,0,0, 4'd0, SR, 0));
        // re-halt reloads the history; resume discards a non-zero count
        vq.push_back(mk(0, 0,1,0,0,0,0,0, 32'h432, 0,0,0, 0,0,0, 4'd0, SR, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,1, 32'h433, 0,0,0, 0,0,1, 4'd5, SH, 0));
        vq.push_back(mk(0, 0,0,1,0,0,0,0, 32'h434, 0,0,0, 0,0,1, 4'd5, SH, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,0, 32'h435, 0,0,0, 0,0,0, 4'd0, SR, 0));
        // clear while halted keeps HALT
        vq.push_back(mk(0, 0,1,0,0,0,0,0, 32'h436, 0,0,0, 0,0,0, 4'd0, SR, 0));
        vq.push_back(mk(0, 0,0,0,0,1,0,0, 32'h437, 0,0,0, 0,0,1, 4'd5, SH, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,0, 32'h438, 0,0,0, 0,0,1, 4'd0, SH, 0));
        vq.push_back(mk(0, 0,0,1,0,0,0,0, 32'h439, 0,0,0, 0,0,1, 4'd0, SH, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,0, 32'h43A, 0,0,0, 0,0,0, 4'd0, SR, 0));

        // round-robin: dm and trc both asking with four entries
        for (int k = 0; k < 4; k++)
            vq.push_back(mk(k == 0, 1,0,0,0,0,0,0, 32'h500 + k, 0,0,0, k != 0,0,0, 4'(k), SR, 0));
        for (int j = 0; j < 4; j++)
            vq.push_back(mk(0, 0,0,0,0,0,1,1, 32'h510 + j, (j % 2) == 0, 0,
                            ((j % 2) == 0) ? 32'h510 + j : 32'h0,
                            (j % 2) != 0, 1, 0, 4'(4 - j), SR, 0));
        vq.push_back(mk(0, 0,0,0,0,0,1,1, 32'h514, 1,1,0, 0,0,0, 4'd0, SR, 0));
        vq.push_back(mk(0, 0,0,0,0,0,0,0, 32'h515, 0,0,0, 0,0,0, 4'd0, SR, 0));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge pcfifo_clk);
            if (vq[i].rst) begin
                cpurst_b = 1'b0;
                #1;
                cpurst_b = 1'b1;
                #1;
            end
            drive(vq[i]);
            #1;
            exp_q.push_back(exp_of(vq[i]));
            check($sformatf("vec%0d", i));
        end

        // asynchronous reset while halted with six entries
        @(negedge pcfifo_clk);
        idle_inputs();
        cpurst_b = 1'b0;
        #1;
        cpurst_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge pcfifo_clk);
            retire_wen_evt = 1'b1;
        end
        @(negedge pcfifo_clk);
        retire_wen_evt   = 1'b0;
        rtu_dtu_halt_ack = 1'b1;
        @(negedge pcfifo_clk);
        rtu_dtu_halt_ack   = 1'b0;
        sif.pcfifo_rd_data = 32'h600;
        #1;
        e = {1'b0, 1'b0, 32'h0, 1'b0, 32'h600, 1'b0, 1'b1, 4'd6, SH, 1'b0, 1'b0};
        exp_q.push_back(e);
        check("halt_cnt6");
        #1;
        cpurst_b = 1'b0;
        #1;
        e = {1'b0, 1'b0, 32'h0, 1'b0, 32'h600, 1'b0, 1'b0, 4'd0, SR, 1'b0, 1'b0};
        exp_q.push_back(e);
        check("rst_in_halt");
        @(negedge pcfifo_clk);
        cpurst_b = 1'b1;
        #1;
        exp_q.push_back(e);
        check("post_rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
